result_frame_tx: RTL and testbench
==================================

RESULT_FRAME_TX -- requirements
Module: result_frame_tx

Interface
REQ-001 The module SHALL have one clock `clk`, and reset `rst_n` SHALL be asynchronous and active-low.
REQ-002 Parameter: HEADER_BYTE, 8'hA5, first byte of every frame.
REQ-003 Parameter: CMD_BYTE, 8'hCE, host request byte that triggers a frame.
REQ-004 Parameter: AUTO_SEND, 1, when 1 every new inference result also triggers a frame.
REQ-005 Port: clk  in  1  system clock, 100 MHz.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: rx_data  in  8  routed command byte.
REQ-008 Port: rx_ready  in  1  one-cycle strobe qualifying rx_data.
REQ-009 Port: inference_done  in  1  level, high while the inference result is valid.
REQ-010 Port: predicted_digit  in  4  argmax class.
REQ-011 Port: scores_flat  in  320  ten signed 32-bit scores; score k occupies bits [32k+31:32k].
REQ-012 Port: tx_data  out  8  byte to UART transmitter.
REQ-013 Port: tx_send  out  1  one-cycle send pulse.
REQ-014 Port: tx_busy  in  1  UART transmitter busy.
REQ-015 Port: frame_busy  out  1  high from trigger acceptance until the last byte completes.
REQ-016 Port: overrun  out  1  sticky; set when a trigger is dropped; cleared when the next frame starts.

Function
REQ-017 A result event SHALL be the rising edge of inference_done, detected with one registered copy of inference_done.
REQ-018 A trigger SHALL be either (rx_ready && rx_data==CMD_BYTE) or (AUTO_SEND && result event).
- On a result event, digit and all scores SHALL be latched into a snapshot register, regardless of state.
- The event SHALL also set result_valid.
REQ-019 On an accepted trigger, the snapshot SHALL be copied into a frame buffer.
- The frame SHALL use the frame buffer only; later snapshot updates SHALL NOT alter a frame in progress.
REQ-020 Frame byte order:
- byte0 = HEADER_BYTE.
- byte1 = {4'h0, digit}, or 8'hFF if result_valid==0.
- bytes2..41 = scores 0..9, each little-endian (LSB first).
- Scores SHALL be sent as zero when result_valid==0.
REQ-021 State machine: IDLE -> LOAD -> ISSUE -> WAIT_HI -> WAIT_LO -> (ISSUE for the next byte | IDLE after the last byte).
REQ-022 ISSUE SHALL assert tx_send for exactly one cycle, only when tx_busy==0, with tx_data held stable from ISSUE until WAIT_LO exit.
REQ-023 WAIT_HI SHALL wait for tx_busy==1, and WAIT_LO SHALL wait for tx_busy==0; there SHALL be no timeout.
REQ-024 A byte counter SHALL count 0 to FRAME_LEN-1 and SHALL return to 0 in IDLE; it SHALL never wrap mid-frame.
REQ-025 Trigger handling while frame_busy==1:
- The trigger SHALL be dropped, and overrun SHALL be set.
- The snapshot SHALL still update on a result event.
REQ-026 A command trigger and a result event in the same cycle SHALL produce one frame containing the new result.
REQ-027 A command byte other than CMD_BYTE SHALL be ignored.
REQ-028 Latency: the first tx_send SHALL occur 2 cycles after the trigger cycle when tx_busy==0.

Reset
REQ-029 While rst_n==0, the following SHALL be 0, and state SHALL be IDLE:
- tx_send, tx_data, frame_busy, overrun
- byte counter, result_valid
- snapshot, frame buffer
- registered copy of inference_done
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, and no further bytes SHALL be sent after release.

Configuration
REQ-031 Macro RESULT_FRAME_CHECKSUM_EN:
- When defined, FRAME_LEN SHALL be 43; byte42 SHALL be the XOR of bytes 1..41 (header excluded).
- When undefined, FRAME_LEN SHALL be 42 and no checksum logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold:
- HEADER_BYTE and CMD_BYTE defaults
- the NO_RESULT code 8'hFF
- the score count (10) and score width (32)
- the FRAME_LEN values
- the state encoding
REQ-033 A sub-module `tx_byte_handshake` SHALL implement the ISSUE/WAIT_HI/WAIT_LO send handshake for one byte, with a byte_req/byte_done interface.

Verification
REQ-034 Reset, then CMD 0xCE with no prior inference -> 42/43 bytes: A5, FF, 40x00, and checksum FF if enabled.
REQ-035 digit=7, score3=32'h12345678, others 0, inference_done rising edge (AUTO_SEND=1) -> A5, 07, score3 bytes 78 56 34 12 at frame bytes 14..17, and checksum 07^08 if enabled.
REQ-036 Second CMD 0xCE mid-frame -> frame completes unchanged, overrun=1, and overrun clears at the next trigger.
REQ-037 tx_busy held high for 1000 cycles before the first byte -> no tx_send until it drops, then exactly one pulse per byte.
REQ-038 rst_n pulsed low at byte 20 -> tx_send stays 0, frame_busy=0, and the next CMD yields a full frame with 0xFF digit.
REQ-039 CMD 0xCE and the inference_done rising edge in the same cycle -> exactly one frame, carrying the new digit.

Source files
------------

// File: rtl/result_frame_tx_pkg.sv
// Shared constants, state encodings and helpers for the result frame transmitter.
// No logic of its own; imported by result_frame_tx and tx_byte_handshake.
// RESULT_FRAME_CHECKSUM_EN adds the checksum fold helper.
package result_frame_tx_pkg;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_BYTE_DEF    = 8'hCE;
    localparam logic [7:0] NO_RESULT       = 8'hFF;

    localparam int NUM_SCORES = 10;
    localparam int SCORE_W    = 32;
    localparam int SCORES_W   = NUM_SCORES * SCORE_W;

    localparam int FRAME_LEN_BASE = 42;
    localparam int FRAME_LEN_CSUM = 43;
    localparam int IDX_W          = 6;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_LOAD,
        FR_SEND
    } frame_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_ISSUE,
        HS_WAIT_HI,
        HS_WAIT_LO
    } hs_state_t;

`ifdef RESULT_FRAME_CHECKSUM_EN
    function automatic logic [7:0] xor_fold(input logic [SCORES_W-1:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < SCORES_W / 8; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction
`endif

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte send handshake towards a UART transmitter: ISSUE, WAIT_HI, WAIT_LO.
// Latency: tx_send pulses the cycle after byte_req when tx_busy is low; byte_done pulses after busy falls.
// Backpressure: holds in ISSUE while tx_busy is high; no timeout on either busy edge.
module tx_byte_handshake
    import result_frame_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_req_i,
    input  logic [7:0] byte_dat_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_send_o,
    output logic       byte_done_o
);

    hs_state_t  state_q;
    logic [7:0] data_q;
    logic       send_q;
    logic       done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HS_IDLE;
            data_q  <= '0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            send_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                HS_IDLE: begin
                    if (byte_req_i) begin
                        data_q <= byte_dat_i;
                        if (!tx_busy_i) begin
                            send_q  <= 1'b1;
                            state_q <= HS_WAIT_HI;
                        end else begin
                            state_q <= HS_ISSUE;
                        end
                    end
                end
                HS_ISSUE: begin
                    if (!tx_busy_i) begin
                        send_q  <= 1'b1;
                        state_q <= HS_WAIT_HI;
                    end
                end
                HS_WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= HS_WAIT_LO;
                    end
                end
                HS_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        done_q  <= 1'b1;
                        state_q <= HS_IDLE;
                    end
                end
                default: state_q <= HS_IDLE;
            endcase
        end
    end

    // data_q only changes on a new request, so it is stable for the whole byte
    assign tx_data_o   = data_q;
    assign tx_send_o   = send_q;
    assign byte_done_o = done_q;

endmodule

// File: rtl/result_frame_tx.sv
// Sends a header/digit/score frame over a byte UART on host command or new inference result.
// Latency: first tx_send 2 cycles after the trigger cycle; triggers during a frame are dropped and flag overrun.
// Backpressure: per-byte tx_busy handshake, no timeout. RESULT_FRAME_CHECKSUM_EN appends an XOR checksum byte.
module result_frame_tx
    import result_frame_tx_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
    parameter logic [7:0] CMD_BYTE    = CMD_BYTE_DEF,
    parameter bit         AUTO_SEND   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    input  logic                inference_done,
    input  logic [3:0]          predicted_digit,
    input  logic [SCORES_W-1:0] scores_flat,
    output logic [7:0]          tx_data,
    output logic                tx_send,
    input  logic                tx_busy,
    output logic                frame_busy,
    output logic                overrun
);

`ifdef RESULT_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic                inf_q;
    logic [3:0]          snap_digit_q;
    logic [SCORES_W-1:0] snap_scores_q;
    logic                result_valid_q;
    logic                fb_valid_q;
    logic [3:0]          fb_digit_q;
    logic [SCORES_W-1:0] fb_scores_q;
    frame_state_t        fstate_q;
    logic [IDX_W-1:0]    cnt_q;
    logic                frame_busy_q;
    logic                overrun_q;

    logic             result_evt;
    logic             trigger;
    logic             hs_done;
    logic             last_byte;
    logic             byte_req;
    logic [IDX_W-1:0] req_idx;
    logic [8:0]       score_off;
    logic [7:0]       digit_byte;
    logic [7:0]       req_byte;

    assign result_evt = inference_done & ~inf_q;
    assign trigger    = (rx_ready && (rx_data == CMD_BYTE)) || (AUTO_SEND && result_evt);
    assign last_byte  = (cnt_q == LAST_IDX);

    // Next byte is requested as soon as the previous one completes, so the index runs one ahead of cnt_q
    assign byte_req  = (fstate_q == FR_LOAD) || ((fstate_q == FR_SEND) && hs_done && !last_byte);
    assign req_idx   = (fstate_q == FR_LOAD) ? '0 : cnt_q + 1'b1;
    assign score_off = {req_idx - 6'd2, 3'b000};
    assign digit_byte = fb_valid_q ? {4'h0, fb_digit_q} : NO_RESULT;

    always_comb begin
        req_byte = '0;
        if (req_idx == '0) begin
            req_byte = HEADER_BYTE;
        end else if (req_idx == 6'd1) begin
            req_byte = digit_byte;
`ifdef RESULT_FRAME_CHECKSUM_EN
        end else if (req_idx == LAST_IDX) begin
            req_byte = digit_byte ^ xor_fold(fb_scores_q);
`endif
        end else begin
            req_byte = fb_scores_q[score_off +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inf_q          <= 1'b0;
            snap_digit_q   <= '0;
            snap_scores_q  <= '0;
            result_valid_q <= 1'b0;
            fb_valid_q     <= 1'b0;
            fb_digit_q     <= '0;
            fb_scores_q    <= '0;
            fstate_q       <= FR_IDLE;
            cnt_q          <= '0;
            frame_busy_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            inf_q <= inference_done;
            if (result_evt) begin
                snap_digit_q   <= predicted_digit;
                snap_scores_q  <= scores_flat;
                result_valid_q <= 1'b1;
            end
            if (trigger && frame_busy_q) begin
                overrun_q <= 1'b1;
            end
            case (fstate_q)
                FR_IDLE: begin
                    cnt_q <= '0;
                    if (trigger) begin
                        fstate_q     <= FR_LOAD;
                        frame_busy_q <= 1'b1;
                        overrun_q    <= 1'b0;
                    end
                end
                FR_LOAD: begin
                    // Copy one cycle after the trigger so a same-cycle result is included
                    fb_valid_q  <= result_valid_q;
                    fb_digit_q  <= snap_digit_q;
                    fb_scores_q <= result_valid_q ? snap_scores_q : '0;
                    fstate_q    <= FR_SEND;
                end
                FR_SEND: begin
                    if (hs_done) begin
                        if (last_byte) begin
                            fstate_q     <= FR_IDLE;
                            frame_busy_q <= 1'b0;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: fstate_q <= FR_IDLE;
            endcase
        end
    end

    tx_byte_handshake u_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_req_i  (byte_req),
        .byte_dat_i  (req_byte),
        .tx_busy_i   (tx_busy),
        .tx_data_o   (tx_data),
        .tx_send_o   (tx_send),
        .byte_done_o (hs_done)
    );

    assign frame_busy = frame_busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx: table of trigger vectors plus hand-written overrun, busy-hold and reset sequences.
// A UART model consumes tx_send pulses and compares each byte against a scoreboard queue of expected frame bytes.
module tb_result_frame_tx;

`ifdef RESULT_FRAME_CHECKSUM_EN
    localparam int FLEN = 43;
`else
    localparam int FLEN = 42;
`endif

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_ready;
    logic         inference_done;
    logic [3:0]   predicted_digit;
    logic [319:0] scores_flat;
    logic [7:0]   tx_data;
    logic         tx_send;
    logic         tx_busy;
    logic         frame_busy;
    logic         overrun;

    logic force_busy;
    int   busy_cnt;
    assign tx_busy = force_busy || (busy_cnt != 0);

    int checks   = 0;
    int failures = 0;
    int sent_cnt = 0;

    typedef struct {
        logic [7:0] b;
        int         pos;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]   last_b;
    logic         m_valid;
    logic [319:0] m_scores;

    typedef struct {
        bit           cmd;
        bit           evt;
        logic [3:0]   digit;
        logic [319:0] scores;
        logic [7:0]   exp_b1;
    } vec_t;
    vec_t vecs[4];

    result_frame_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .inference_done  (inference_done),
        .predicted_digit (predicted_digit),
        .scores_flat     (scores_flat),
        .tx_data         (tx_data),
        .tx_send         (tx_send),
        .tx_busy         (tx_busy),
        .frame_busy      (frame_busy),
        .overrun         (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired got=%0d sent want=finish", sent_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_frame(input logic [7:0] b1);
        exp_t       e;
        logic [7:0] cs;
        e.b = 8'hA5; e.pos = 0; exp_q.push_back(e);
        e.b = b1;    e.pos = 1; exp_q.push_back(e);
        cs = b1;
        for (int j = 0; j < 40; j++) begin
            e.b   = m_valid ? m_scores[8*j +: 8] : 8'h00;
            e.pos = j + 2;
            cs    = cs ^ e.b;
            exp_q.push_back(e);
        end
        if (FLEN == 43) begin
            e.b = cs; e.pos = 42; exp_q.push_back(e);
        end
    endtask

    task automatic do_trigger(input bit cmd, input bit evt, input logic [3:0] d,
                              input logic [319:0] s, input bit chk_lat);
        rx_data  = 8'hCE;
        rx_ready = cmd;
        if (evt) begin
            predicted_digit = d;
            scores_flat     = s;
            inference_done  = 1'b1;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        if (chk_lat) begin
            check(tx_send == 1'b0, "lat_c1_send", 32'(tx_send), 32'd0);
            check(frame_busy == 1'b1, "lat_c1_busy", 32'(frame_busy), 32'd1);
            @(negedge clk);
            check(tx_send == 1'b1, "lat_c2_send", 32'(tx_send), 32'd1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (frame_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(!frame_busy, {name, "_timeout"}, 32'(frame_busy), 32'd0);
        @(negedge clk);
        check(exp_q.size() == 0, {name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_sent(input int target);
        int n;
        n = 0;
        while (sent_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(sent_cnt >= target, "wait_sent", 32'(sent_cnt), 32'(target));
    endtask

    // UART model and scoreboard consumer
    initial begin
        exp_t e;
        busy_cnt = 0;
        last_b   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy_cnt != 0) begin
                    check(tx_data == last_b, "tx_data_hold", 32'(tx_data), 32'(last_b));
                end
                if (tx_send) begin
                    check(!tx_busy, "send_while_busy", 32'(tx_busy), 32'd0);
                    sent_cnt++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_send", 32'(tx_data), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check(tx_data == e.b, $sformatf("byte%0d", e.pos), 32'(tx_data), 32'(e.b));
                    end
                    last_b   = tx_data;
                    busy_cnt = 4;
                end else if (busy_cnt != 0) begin
                    busy_cnt--;
                end
            end
        end
    end

    initial begin
        logic [319:0] s;
        int           base;

        rst_n           = 1'b0;
        rx_data         = 8'h00;
        rx_ready        = 1'b0;
        inference_done  = 1'b0;
        predicted_digit = 4'h0;
        scores_flat     = '0;
        force_busy      = 1'b0;
        m_valid         = 1'b0;
        m_scores        = '0;

        s = '0; s[3*32 +: 32] = 32'h12345678;
        vecs[0] = '{cmd: 1'b0, evt: 1'b1, digit: 4'd7, scores: s, exp_b1: 8'h07};
        vecs[1] = '{cmd: 1'b1, evt: 1'b0, digit: 4'd0, scores: '0, exp_b1: 8'h07};
        s = '0; s[0 +: 32] = 32'hFFFFFFFF; s[9*32 +: 32] = 32'h80000001;
        vecs[2] = '{cmd: 1'b1, evt: 1'b1, digit: 4'd9, scores: s, exp_b1: 8'h09};
        s = '0; s[5*32 +: 32] = 32'h0000A5CE;
        vecs[3] = '{cmd: 1'b0, evt: 1'b1, digit: 4'd0, scores: s, exp_b1: 8'h00};

        repeat (3) @(negedge clk);
        check(tx_send == 1'b0, "rst_tx_send", 32'(tx_send), 32'd0);
        check(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 32'd0);
        check(frame_busy == 1'b0, "rst_frame_busy", 32'(frame_busy), 32'd0);
        check(overrun == 1'b0, "rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // command with no result yet
        push_frame(8'hFF);
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b1);
        wait_idle("nores");
        check(overrun == 1'b0, "nores_overrun", 32'(overrun), 32'd0);

        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check(frame_busy == 1'b0, "bad_cmd_busy", 32'(frame_busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].evt) begin
                m_valid  = 1'b1;
                m_scores = vecs[i].scores;
            end
            push_frame(vecs[i].exp_b1);
            do_trigger(vecs[i].cmd, vecs[i].evt, vecs[i].digit, vecs[i].scores, 1'b1);
            wait_idle($sformatf("vec%0d", i));
            inference_done = 1'b0;
            @(negedge clk);
        end

        // triggers mid-frame are dropped; snapshot still follows the new result
        push_frame(8'h00);
        base = sent_cnt;
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b1);
        wait_sent(base + 5);
        s = '0; s[1*32 +: 32] = 32'hCAFEF00D;
        rx_data         = 8'hCE;
        rx_ready        = 1'b1;
        predicted_digit = 4'd3;
        scores_flat     = s;
        inference_done  = 1'b1;
        m_valid         = 1'b1;
        m_scores        = s;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_idle("ovr");
        check(overrun == 1'b1, "overrun_set", 32'(overrun), 32'd1);
        push_frame(8'h03);
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b1);
        check(overrun == 1'b0, "overrun_clr", 32'(overrun), 32'd0);
        wait_idle("after_ovr");
        inference_done = 1'b0;
        @(negedge clk);

        // transmitter busy for a long time before the first byte
        push_frame(8'h03);
        force_busy = 1'b1;
        base = sent_cnt;
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b0);
        repeat (1000) @(negedge clk);
        check(sent_cnt == base, "hold_no_send", 32'(sent_cnt - base), 32'd0);
        check(frame_busy == 1'b1, "hold_busy", 32'(frame_busy), 32'd1);
        force_busy = 1'b0;
        wait_idle("hold");
        check(sent_cnt == base + FLEN, "hold_pulse_count", 32'(sent_cnt - base), 32'(FLEN));

        // reset in the middle of a frame
        push_frame(8'h03);
        base = sent_cnt;
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b1);
        wait_sent(base + 21);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_valid  = 1'b0;
        m_scores = '0;
        repeat (3) @(negedge clk);
        check(tx_send == 1'b0, "midrst_tx_send", 32'(tx_send), 32'd0);
        check(tx_data == 8'h00, "midrst_tx_data", 32'(tx_data), 32'd0);
        check(frame_busy == 1'b0, "midrst_frame_busy", 32'(frame_busy), 32'd0);
        check(overrun == 1'b0, "midrst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        base = sent_cnt;
        repeat (100) @(negedge clk);
        check(sent_cnt == base, "postrst_no_send", 32'(sent_cnt - base), 32'd0);
        check(frame_busy == 1'b0, "postrst_idle", 32'(frame_busy), 32'd0);
        push_frame(8'hFF);
        do_trigger(1'b1, 1'b0, 4'h0, '0, 1'b1);
        wait_idle("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
